// File: rtl/rp_bfm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rp_bfm_pkg
//  Brief    : Shared types and constants for the root-port BFM blocks
//             (tag tracker, packet sender/receiver, shared memory).
//  Revision : 1.0 - initial release
// ============================================================================
package rp_bfm_pkg;

    // Widest byte count carried in the shared header structs (4096 bytes max).
    localparam int RP_BCNT_W = 13;

    // Completion status: successful completion.
    localparam logic [2:0] RP_CPL_SC = 3'b000;

    // Retire error codes.
    localparam logic [1:0] RP_RETIRE_OK      = 2'b00;
    localparam logic [1:0] RP_RETIRE_STATUS  = 2'b01;
    localparam logic [1:0] RP_RETIRE_TIMEOUT = 2'b10;

    // Completer identity (function routing).
    typedef struct packed {
        logic        vf_active;
        logic [7:0]  pfn;
        logic [10:0] vfn;
    } t_rp_id;

    // What is recorded for a non-posted request at allocation time.
    typedef struct packed {
        logic [15:0]          requester_id;
        t_rp_id               completer;
        logic [RP_BCNT_W-1:0] byte_count;
    } t_rp_req_info;

    // Fields of an incoming completion header used for matching.
    typedef struct packed {
        logic [15:0]          requester_id;
        t_rp_id               completer;
        logic [2:0]           status;
        logic [RP_BCNT_W-1:0] byte_count;
        logic [RP_BCNT_W-1:0] len_bytes;
    } t_rp_cpl_info;

endpackage : rp_bfm_pkg
`default_nettype wire

// File: rtl/rp_tag_freelist.sv
`default_nettype none
// ============================================================================
//  Module   : rp_tag_freelist
//  Brief    : Lowest-index priority encoder. Used once to pick the lowest free
//             tag and once to pick the lowest timeout-pending tag.
//  Revision : 1.0 - initial release
// ============================================================================
module rp_tag_freelist #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    assign found_o = |req_i;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule : rp_tag_freelist
`default_nettype wire

// File: rtl/rp_cpl_tag_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : rp_cpl_tag_tracker
//  Brief    : Outstanding non-posted request tracker. Allocates the lowest free
//             tag, checks completions against the recorded IDs and remaining
//             byte count, supports split completions and retires tags.
//  Options  : RP_TAG_TIMEOUT_EN - per-tag completion timeout (err 10 retires)
//  Revision : 1.0 - initial release
// ============================================================================
module rp_cpl_tag_tracker
    import rp_bfm_pkg::*;
#(
    parameter  int NUM_TAGS       = 64,
    parameter  int BCNT_W         = 13,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int TAG_W          = $clog2(NUM_TAGS)
) (
    input  logic              avl_clk,
    input  logic              avl_rst_n,
    input  logic              i_clear,
    input  logic              i_alloc_valid,
    output logic              o_alloc_ready,
    output logic [TAG_W-1:0]  o_alloc_tag,
    input  t_rp_req_info      i_alloc_info,
    input  logic              i_cpl_valid,
    output logic              o_cpl_ready,
    input  logic [TAG_W-1:0]  i_cpl_tag,
    input  t_rp_cpl_info      i_cpl_hdr,
    output logic              o_retire_valid,
    output logic [TAG_W-1:0]  o_retire_tag,
    output logic [1:0]        o_retire_err,
    output logic              o_unexp_valid,
    output logic [TAG_W-1:0]  o_unexp_tag,
    output logic [TAG_W:0]    o_outstanding
);

    localparam logic [TAG_W:0] C_ONE = {{TAG_W{1'b0}}, 1'b1};

    // Elaboration-time sanity check of the configuration.
    if (BCNT_W > RP_BCNT_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rp_cpl_tag_tracker: unsupported BCNT_W / TIMEOUT_CYCLES");
    end

    // Per-tag state.
    logic [NUM_TAGS-1:0] active_q, active_d;
    logic [BCNT_W-1:0]   rem_q [NUM_TAGS];
    logic [BCNT_W-1:0]   rem_d [NUM_TAGS];
    logic [15:0]         req_id_q [NUM_TAGS];
    t_rp_id              cmpl_id_q [NUM_TAGS];

    // Output registers.
    logic              ret_valid_q, unexp_valid_q;
    logic [TAG_W-1:0]  ret_tag_q, unexp_tag_q;
    logic [1:0]        ret_err_q;
    logic [TAG_W:0]    out_q;

    // Free-tag selection.
    logic              w_free_found;
    logic [TAG_W-1:0]  w_free_tag;

    rp_tag_freelist #(.N(NUM_TAGS), .W(TAG_W)) u_free_enc (
        .req_i   (~active_q),
        .found_o (w_free_found),
        .idx_o   (w_free_tag)
    );

    assign o_alloc_ready = w_free_found & ~i_clear;
    assign o_alloc_tag   = w_free_tag;
    assign o_cpl_ready   = ~i_clear;

    logic              w_alloc_fire, w_cpl_fire, w_is_sc, w_id_ok, w_bc_ok;
    logic              w_cpl_match, w_cpl_unexp, w_cpl_done, w_cpl_split;
    logic [BCNT_W-1:0] w_cpl_rem, w_len;

    assign w_alloc_fire = i_alloc_valid & o_alloc_ready;
    assign w_cpl_fire   = i_cpl_valid & ~i_clear;
    assign w_is_sc      = (i_cpl_hdr.status == RP_CPL_SC);
    assign w_cpl_rem    = rem_q[i_cpl_tag];
    assign w_len        = i_cpl_hdr.len_bytes[BCNT_W-1:0];
    // Byte-count agreement only matters for successful completions.
    assign w_id_ok      = active_q[i_cpl_tag]
                        && (req_id_q[i_cpl_tag] == i_cpl_hdr.requester_id)
                        && (cmpl_id_q[i_cpl_tag] == i_cpl_hdr.completer);
    assign w_bc_ok      = !w_is_sc || (i_cpl_hdr.byte_count[BCNT_W-1:0] == w_cpl_rem);
    assign w_cpl_match  = w_cpl_fire & w_id_ok & w_bc_ok;
    assign w_cpl_unexp  = w_cpl_fire & ~(w_id_ok & w_bc_ok);
    assign w_cpl_done   = w_cpl_match & (~w_is_sc | (w_len >= w_cpl_rem));
    assign w_cpl_split  = w_cpl_match & w_is_sc & (w_len < w_cpl_rem);

    logic              w_tmo_retire;
    logic [TAG_W-1:0]  w_tmo_tag;

`ifdef RP_TAG_TIMEOUT_EN
    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  C_TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0]    tmo_q [NUM_TAGS];
    logic [NUM_TAGS-1:0] w_pend_arb;
    logic                w_tmo_found;

    // Pending tags, minus one whose completion is being accepted this cycle.
    always_comb begin
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_pend_arb[i] = active_q[i] && (tmo_q[i] == C_TMO_MAX);
        end
        if (w_cpl_match) begin
            w_pend_arb[i_cpl_tag] = 1'b0;
        end
    end

    rp_tag_freelist #(.N(NUM_TAGS), .W(TAG_W)) u_tmo_enc (
        .req_i   (w_pend_arb),
        .found_o (w_tmo_found),
        .idx_o   (w_tmo_tag)
    );

    assign w_tmo_retire = w_tmo_found & ~w_cpl_done & ~i_clear;

    // Per-tag timeout counters: reload on alloc/split, hold at the limit.
    always_ff @(posedge avl_clk or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++) tmo_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (i_clear) begin
                    tmo_q[i] <= '0;
                end else if ((w_alloc_fire && w_free_tag == TAG_W'(i)) ||
                             (w_cpl_split && i_cpl_tag == TAG_W'(i))) begin
                    tmo_q[i] <= '0;
                end else if (active_q[i] && tmo_q[i] != C_TMO_MAX) begin
                    tmo_q[i] <= tmo_q[i] + 1'b1;
                end
            end
        end
    end
`else
    assign w_tmo_retire = 1'b0;
    assign w_tmo_tag    = '0;
`endif

    // Completion retires take the retire port ahead of timeout retires.
    logic              w_ret_fire;
    logic [TAG_W-1:0]  w_ret_tag;
    logic [1:0]        w_ret_err;

    assign w_ret_fire = w_cpl_done | w_tmo_retire;
    assign w_ret_tag  = w_cpl_done ? i_cpl_tag : w_tmo_tag;
    assign w_ret_err  = w_cpl_done ? (w_is_sc ? RP_RETIRE_OK : RP_RETIRE_STATUS)
                                   : RP_RETIRE_TIMEOUT;

    // Next state of active bits and remaining byte counts.
    always_comb begin
        active_d = active_q;
        for (int i = 0; i < NUM_TAGS; i++) rem_d[i] = rem_q[i];
        if (i_clear) begin
            active_d = '0;
            for (int i = 0; i < NUM_TAGS; i++) rem_d[i] = '0;
        end else begin
            if (w_alloc_fire) begin
                active_d[w_free_tag] = 1'b1;
                rem_d[w_free_tag]    = i_alloc_info.byte_count[BCNT_W-1:0];
            end
            if (w_ret_fire) begin
                active_d[w_ret_tag] = 1'b0;
                rem_d[w_ret_tag]    = '0;
            end
            if (w_cpl_split) begin
                rem_d[i_cpl_tag] = w_cpl_rem - w_len;
            end
        end
    end

    // Per-tag state and output registers.
    always_ff @(posedge avl_clk or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            active_q      <= '0;
            for (int i = 0; i < NUM_TAGS; i++) rem_q[i] <= '0;
            ret_valid_q   <= 1'b0;
            ret_tag_q     <= '0;
            ret_err_q     <= '0;
            unexp_valid_q <= 1'b0;
            unexp_tag_q   <= '0;
            out_q         <= '0;
        end else begin
            active_q      <= active_d;
            for (int i = 0; i < NUM_TAGS; i++) rem_q[i] <= rem_d[i];
            ret_valid_q   <= w_ret_fire;
            unexp_valid_q <= w_cpl_unexp;
            if (w_ret_fire) begin
                ret_tag_q <= w_ret_tag;
                ret_err_q <= w_ret_err;
            end
            if (w_cpl_unexp) begin
                unexp_tag_q <= i_cpl_tag;
            end
            if (i_clear) begin
                out_q <= '0;
            end else if (w_alloc_fire && !w_ret_fire) begin
                out_q <= out_q + C_ONE;
            end else if (!w_alloc_fire && w_ret_fire) begin
                out_q <= out_q - C_ONE;
            end
        end
    end

    // Identity recorded at allocation; only meaningful while the tag is active.
    always_ff @(posedge avl_clk) begin
        if (w_alloc_fire) begin
            req_id_q[w_free_tag]  <= i_alloc_info.requester_id;
            cmpl_id_q[w_free_tag] <= i_alloc_info.completer;
        end
    end

    assign o_retire_valid = ret_valid_q;
    assign o_retire_tag   = ret_tag_q;
    assign o_retire_err   = ret_err_q;
    assign o_unexp_valid  = unexp_valid_q;
    assign o_unexp_tag    = unexp_tag_q;
    assign o_outstanding  = out_q;

endmodule : rp_cpl_tag_tracker
`default_nettype wire

// File: tb/tb_rp_cpl_tag_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rp_cpl_tag_tracker
//  Brief    : Self-checking bench for rp_cpl_tag_tracker. Expected retire and
//             unexpected-completion events are queued with their due cycle
//             when stimulus is driven and matched as the DUT reports them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rp_cpl_tag_tracker;
    import rp_bfm_pkg::*;

    localparam int NUM_TAGS = 64;
    localparam int TAG_W    = 6;
    localparam int TMO_CYC  = 512;

    logic              clk, rst_n, clear;
    logic              alloc_valid, alloc_ready, cpl_valid, cpl_ready;
    logic [TAG_W-1:0]  alloc_tag, cpl_tag, retire_tag, unexp_tag;
    t_rp_req_info      alloc_info;
    t_rp_cpl_info      cpl_hdr;
    logic              retire_valid, unexp_valid;
    logic [1:0]        retire_err;
    logic [TAG_W:0]    outstanding;

    rp_cpl_tag_tracker #(
        .NUM_TAGS       (NUM_TAGS),
        .BCNT_W         (13),
        .TIMEOUT_CYCLES (TMO_CYC)
    ) dut (
        .avl_clk        (clk),
        .avl_rst_n      (rst_n),
        .i_clear        (clear),
        .i_alloc_valid  (alloc_valid),
        .o_alloc_ready  (alloc_ready),
        .o_alloc_tag    (alloc_tag),
        .i_alloc_info   (alloc_info),
        .i_cpl_valid    (cpl_valid),
        .o_cpl_ready    (cpl_ready),
        .i_cpl_tag      (cpl_tag),
        .i_cpl_hdr      (cpl_hdr),
        .o_retire_valid (retire_valid),
        .o_retire_tag   (retire_tag),
        .o_retire_err   (retire_err),
        .o_unexp_valid  (unexp_valid),
        .o_unexp_tag    (unexp_tag),
        .o_outstanding  (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        int tag;
        int err;
        int due;   // -1: any cycle
    } exp_t;

    exp_t ret_q[$];
    exp_t unx_q[$];

    task automatic exp_ret(input int tag, input int err);
        exp_t e;
        e.tag = tag; e.err = err; e.due = cyc + 1;
        ret_q.push_back(e);
    endtask

    task automatic exp_unx(input int tag);
        exp_t e;
        e.tag = tag; e.err = 0; e.due = cyc + 1;
        unx_q.push_back(e);
    endtask

    // Scoreboard: match every reported event against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (retire_valid) begin
                if (ret_q.size() == 0) begin
                    check_val("spurious_retire", {26'd0, retire_tag}, 32'hFFFF);
                end else begin
                    e = ret_q.pop_front();
                    check_val("retire_tag", {26'd0, retire_tag}, e.tag);
                    check_val("retire_err", {30'd0, retire_err}, e.err);
                    if (e.due >= 0) check_val("retire_cycle", cyc, e.due);
                end
            end
            if (unexp_valid) begin
                if (unx_q.size() == 0) begin
                    check_val("spurious_unexp", {26'd0, unexp_tag}, 32'hFFFF);
                end else begin
                    e = unx_q.pop_front();
                    check_val("unexp_tag", {26'd0, unexp_tag}, e.tag);
                    if (e.due >= 0) check_val("unexp_cycle", cyc, e.due);
                end
            end
            if (ret_q.size() > 0 && ret_q[0].due >= 0 && ret_q[0].due < cyc) begin
                e = ret_q.pop_front();
                check_val("missing_retire", 32'hFFFF, e.tag);
            end
            if (unx_q.size() > 0 && unx_q[0].due >= 0 && unx_q[0].due < cyc) begin
                e = unx_q.pop_front();
                check_val("missing_unexp", 32'hFFFF, e.tag);
            end
        end
    end

    function automatic t_rp_req_info mk_req(input int bc);
        t_rp_req_info r;
        r.requester_id = 16'h0100;
        r.completer    = '0;
        r.byte_count   = 13'(bc);
        return r;
    endfunction

    function automatic t_rp_cpl_info mk_cpl(input int rid, input int pfn, input int st,
                                            input int bc, input int len);
        t_rp_cpl_info c;
        c.requester_id      = 16'(rid);
        c.completer         = '0;
        c.completer.pfn     = 8'(pfn);
        c.status            = 3'(st);
        c.byte_count        = 13'(bc);
        c.len_bytes         = 13'(len);
        return c;
    endfunction

    function automatic int tag_bc(input int t);
        return (t == 5) ? 8 : (t == 2) ? 256 : (t == 7) ? 64 : 16;
    endfunction

    // Apply inputs for one clock; called #1 after a rising edge.
    task automatic drive(input logic av, input t_rp_req_info ai, input logic cv,
                         input int ct, input t_rp_cpl_info ch);
        alloc_valid = av; alloc_info = ai;
        cpl_valid = cv; cpl_tag = TAG_W'(ct); cpl_hdr = ch;
        @(posedge clk); #1;
        alloc_valid = 1'b0; cpl_valid = 1'b0;
    endtask

    task automatic do_alloc(input int exp_tag, input int bc);
        check_val("alloc_ready", {31'd0, alloc_ready}, 1);
        check_val("alloc_tag", {26'd0, alloc_tag}, exp_tag);
        drive(1'b1, mk_req(bc), 1'b0, 0, '0);
    endtask

    task automatic cpl(input int tag, input t_rp_cpl_info ch);
        drive(1'b0, '0, 1'b1, tag, ch);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        alloc_valid = 1'b0; alloc_info = '0;
        cpl_valid = 1'b0; cpl_tag = '0; cpl_hdr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_retire_valid", {31'd0, retire_valid}, 0);
        check_val("rst_unexp_valid", {31'd0, unexp_valid}, 0);
        check_val("rst_retire_tag", {26'd0, retire_tag}, 0);
        check_val("rst_retire_err", {30'd0, retire_err}, 0);
        check_val("rst_unexp_tag", {26'd0, unexp_tag}, 0);
        check_val("rst_outstanding", {25'd0, outstanding}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("cpl_ready", {31'd0, cpl_ready}, 1);

        // Fill the table.
        for (int t = 0; t < NUM_TAGS; t++) do_alloc(t, tag_bc(t));
        check_val("full_ready", {31'd0, alloc_ready}, 0);
        check_val("full_outstanding", {25'd0, outstanding}, 64);

        // Single SC completion retires tag 5; it is grantable immediately after.
        exp_ret(5, 0);
        cpl(5, mk_cpl(16'h0100, 0, 0, 8, 8));
        check_val("regrant_ready", {31'd0, alloc_ready}, 1);
        check_val("out_after_ret5", {25'd0, outstanding}, 63);
        do_alloc(5, 8);
        check_val("out_refull", {25'd0, outstanding}, 64);

        // Split completion: retire only after the second part.
        cpl(2, mk_cpl(16'h0100, 0, 0, 256, 128));
        exp_ret(2, 0);
        cpl(2, mk_cpl(16'h0100, 0, 0, 128, 128));
        check_val("out_after_split", {25'd0, outstanding}, 63);

        // Completer mismatch is unexpected and leaves tag 7 intact.
        exp_unx(7);
        cpl(7, mk_cpl(16'h0100, 1, 0, 64, 64));
        exp_ret(7, 0);
        cpl(7, mk_cpl(16'h0100, 0, 0, 64, 64));

        // Completion to an idle tag.
        exp_ret(9, 0);
        cpl(9, mk_cpl(16'h0100, 0, 0, 16, 16));
        exp_unx(9);
        cpl(9, mk_cpl(16'h0100, 0, 0, 16, 16));
        check_val("out_idle9", {25'd0, outstanding}, 61);

        // Allocate and complete tag 2 in the same cycle: completion unexpected.
        check_val("alloc_tag_2", {26'd0, alloc_tag}, 2);
        exp_unx(2);
        drive(1'b1, mk_req(16), 1'b1, 2, mk_cpl(16'h0100, 0, 0, 16, 16));
        check_val("out_same_tag", {25'd0, outstanding}, 62);

        // Allocate tag 7 while retiring tag 13 with len > remaining.
        check_val("alloc_tag_7", {26'd0, alloc_tag}, 7);
        exp_ret(13, 0);
        drive(1'b1, mk_req(16), 1'b1, 13, mk_cpl(16'h0100, 0, 0, 16, 32));
        check_val("out_alloc_and_retire", {25'd0, outstanding}, 62);
        check_val("alloc_tag_9", {26'd0, alloc_tag}, 9);

        // Non-SC status retires with err 01 regardless of byte count.
        exp_ret(10, 1);
        cpl(10, mk_cpl(16'h0100, 0, 1, 999, 4));
        // SC byte-count mismatch and requester mismatch are unexpected.
        exp_unx(11);
        cpl(11, mk_cpl(16'h0100, 0, 0, 20, 16));
        exp_unx(12);
        cpl(12, mk_cpl(16'h0200, 0, 0, 16, 16));
        check_val("out_before_clear", {25'd0, outstanding}, 61);

        // Soft clear: a completion offered during clear must be ignored.
        clear = 1'b1; #1;
        check_val("clear_alloc_ready", {31'd0, alloc_ready}, 0);
        check_val("clear_cpl_ready", {31'd0, cpl_ready}, 0);
        cpl(12, mk_cpl(16'h0100, 0, 0, 16, 16));
        clear = 1'b0; #1;
        check_val("out_after_clear", {25'd0, outstanding}, 0);
        check_val("alloc_tag_after_clear", {26'd0, alloc_tag}, 0);

        // Ten active tags, then clear: count drops, no retire pulses.
        for (int t = 0; t < 10; t++) do_alloc(t, 16);
        check_val("out_ten", {25'd0, outstanding}, 10);
        clear = 1'b1;
        drive(1'b0, '0, 1'b0, 0, '0);
        clear = 1'b0;
        check_val("out_ten_cleared", {25'd0, outstanding}, 0);
        repeat (5) @(posedge clk);
        #1;

`ifdef RP_TAG_TIMEOUT_EN
        // Two tags left without completions time out in index order.
        begin
            exp_t e;
            do_alloc(0, 16);
            do_alloc(1, 16);
            e.tag = 0; e.err = 2; e.due = -1; ret_q.push_back(e);
            e.tag = 1; e.err = 2; e.due = -1; ret_q.push_back(e);
            for (int k = 0; k < TMO_CYC + 50 && ret_q.size() > 0; k++) @(posedge clk);
            #1;
            @(posedge clk); #1;
            check_val("out_after_timeout", {25'd0, outstanding}, 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check_val("pending_retires", ret_q.size(), 0);
        check_val("pending_unexp", unx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rp_cpl_tag_tracker
`default_nettype wire
